dout_bank_serializer: RTL and testbench
=======================================

DOUT_BANK_SERIALIZER -- requirements
Module: dout_bank_serializer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 16: number of BRAM banks read in sequence.
REQ-002 SHALL have parameter ROWS_PER_BANK, default 4: consecutive output rows mapped to one bank.
REQ-003 SHALL have parameter WORDS_PER_ROW, default 192: BRAM words per row.
REQ-004 SHALL have parameter BRAM_DW, default 64: BRAM word width.
REQ-005 SHALL have parameter AXI_DW, default 32: output beat width; BRAM_DW/AXI_DW (RATIO) integer power of 2, >=1.
REQ-006 SHALL have parameter ADDR_W, default 14: BRAM address width.
REQ-007 SHALL have parameter BRAM_LAT, default 1: BRAM read latency in cycles, 1..4.
REQ-008 SHALL have port axi_ACLK  in  1  sole clock, rising edge.
REQ-009 SHALL have port axi_ARESETN  in  1  reset, asynchronous, active-low.
REQ-010 SHALL have port stage_start  in  1  level; a rising edge starts a frame.
REQ-011 SHALL have port stage_abort  in  1  synchronous flush to IDLE.
REQ-012 SHALL have port write_data  out  AXI_DW  output beat.
REQ-013 SHALL have port write_valid  out  1  beat valid.
REQ-014 SHALL have port write_ready  in  1  sink accepts beat.
REQ-015 SHALL have port bram_enb  out  NUM_BANKS  per-bank read enable.
REQ-016 SHALL have port bram_addrb  out  NUM_BANKS*ADDR_W  per-bank address, bank b at bits [b*ADDR_W +: ADDR_W].
REQ-017 SHALL have port bram_doutb  in  NUM_BANKS*BRAM_DW  per-bank read data, same packing.
REQ-018 SHALL have port busy  out  1  high from start until done or abort.
REQ-019 SHALL have port frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-020 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-021 SHALL start only on a stage_start rising edge (registered previous value) seen in IDLE; edges in other states are ignored.
REQ-022 In RUN: one BRAM read issued per cycle when buffer occupancy plus in-flight reads < BRAM_LAT+2.
REQ-023 Read order: row r = 0..NUM_BANKS*ROWS_PER_BANK-1, word w = 0..WORDS_PER_ROW-1; bank = r / ROWS_PER_BANK; address = (r mod ROWS_PER_BANK)*WORDS_PER_ROW + w.
REQ-024 Only the selected bank's bram_enb SHALL be asserted, for exactly one cycle per read; unselected addresses are 0.
REQ-025 Return data SHALL be taken from the bank recorded at issue time, captured BRAM_LAT cycles after issue into a BRAM_LAT+2 deep FIFO; the FIFO never overflows.
REQ-026 Each BRAM word SHALL emit RATIO beats, least-significant AXI_DW slice first.
REQ-027 write_valid SHALL be high whenever a beat is available; while write_valid & !write_ready, write_data SHALL stay stable and write_valid SHALL stay high.
REQ-028 A beat transfers on write_valid & write_ready; back-to-back transfers at one beat per cycle SHALL be sustained with write_ready held high.
REQ-029 RUN -> DRAIN after the last read issues; DRAIN -> DONE on the last beat transfer; DONE lasts one cycle with frame_done=1, then IDLE.
REQ-030 Total beats per frame = NUM_BANKS*ROWS_PER_BANK*WORDS_PER_ROW*RATIO, exactly.
REQ-031 stage_abort in any state SHALL, next cycle, return to IDLE, empty the FIFO, discard in-flight returns, and drop write_valid and busy; frame_done SHALL NOT pulse; abort has priority over a simultaneous start.
REQ-032 busy SHALL be 1 in RUN, DRAIN, DONE; 0 in IDLE.

Reset
REQ-033 On axi_ARESETN=0, immediately and asynchronously: state IDLE, counters and FIFO cleared, the registered stage_start value cleared, write_valid=0, write_data=0, bram_enb=0, bram_addrb=0, busy=0, frame_done=0.
REQ-034 After reset release, a stage_start held high SHALL count as a rising edge.

Verification
REQ-035 NUM_BANKS=2, ROWS_PER_BANK=2, WORDS_PER_ROW=3, RATIO=2, BRAM_LAT=1, bank b word a = {b,a} pattern, ready always 1 -> 24 beats in order, bank0 rows0-1 then bank1, low half first, frame_done once after beat 24.
REQ-036 Same config, write_ready random 30% -> identical beat sequence, no data change while stalled, no lost or duplicated beats.
REQ-037 BRAM_LAT=3, ready held 0 for 20 cycles after start -> at most 5 reads issued before first accept, FIFO never overflows.
REQ-038 stage_abort at beat 10 -> write_valid 0 next cycle, no frame_done; new start then replays all 24 beats from beat 0.
REQ-039 stage_start re-pulsed mid-frame -> ignored; reset asserted mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/dout_bank_serializer_if.sv
// Output beat channel of the bank serializer.
// Master drives data/valid, slave drives ready.
interface dout_bank_serializer_if #(
  parameter int AXI_DW = 32
);
  logic [AXI_DW-1:0] write_data;
  logic              write_valid;
  logic              write_ready;

  modport master (
    output write_data,
    output write_valid,
    input  write_ready
  );

  modport slave (
    input  write_data,
    input  write_valid,
    output write_ready
  );
endinterface

// File: rtl/dout_bank_serializer.sv
// Reads NUM_BANKS BRAM banks row by row and serializes
// each word into RATIO output beats, LSB slice first.
module dout_bank_serializer #(
  parameter int NUM_BANKS     = 16,
  parameter int ROWS_PER_BANK = 4,
  parameter int WORDS_PER_ROW = 192,
  parameter int BRAM_DW       = 64,
  parameter int AXI_DW        = 32,
  parameter int ADDR_W        = 14,
  parameter int BRAM_LAT      = 1
) (
  input  logic                        axi_ACLK,
  input  logic                        axi_ARESETN,
  input  logic                        stage_start,
  input  logic                        stage_abort,
  dout_bank_serializer_if.master      wr,
  output logic [NUM_BANKS-1:0]        bram_enb,
  output logic [NUM_BANKS*ADDR_W-1:0] bram_addrb,
  input  logic [NUM_BANKS*BRAM_DW-1:0] bram_doutb,
  output logic                        busy,
  output logic                        frame_done
);
  localparam int RATIO = BRAM_DW / AXI_DW;
  localparam int DEPTH = BRAM_LAT + 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int KW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam logic [ADDR_W-1:0] A_LAST =
    ADDR_W'(ROWS_PER_BANK * WORDS_PER_ROW - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_BANKS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);
  localparam logic [BW-1:0] B_LAST = BW'(RATIO - 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_n;
  logic start_q, rise;
  logic [KW-1:0] bank;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0] pend, cnt;
  logic [PW-1:0] wp, rp;
  logic [BW-1:0] beat;
  logic [BRAM_DW-1:0] mem [DEPTH];
  logic [BRAM_LAT-1:0] pv;
  logic [KW-1:0] pb [BRAM_LAT];
  logic issue, last, xfer, pop, cap;

  // pend = buffered words + reads still in flight
  assign rise  = stage_start & ~start_q;
  assign last  = (bank == K_LAST) && (addr == A_LAST);
  assign issue = (state == RUN) && !stage_abort
              && (pend < C_DEPTH);
  assign wr.write_valid = (cnt != '0);
  assign xfer  = wr.write_valid & wr.write_ready;
  assign pop   = xfer && (beat == B_LAST);
  assign cap   = pv[BRAM_LAT-1];
  assign wr.write_data = wr.write_valid
    ? mem[rp][int'(beat)*AXI_DW +: AXI_DW] : '0;
  assign busy = (state != IDLE);
  assign frame_done = (state == DONE);

  // state register and start edge history
  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      start_q <= stage_start;
    end
  end

  // next-state logic, abort wins over everything
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (rise) state_n = RUN;
      RUN:   if (issue && last) state_n = DRAIN;
      DRAIN: if (pop && pend == CW'(1)) state_n = DONE;
      DONE:  state_n = IDLE;
    endcase
    if (stage_abort) state_n = IDLE;
  end

  // one-hot read strobe for the bank being read
  always_comb begin
    bram_enb   = '0;
    bram_addrb = '0;
    if (issue) begin
      bram_enb[bank] = 1'b1;
      bram_addrb[int'(bank)*ADDR_W +: ADDR_W] = addr;
    end
  end

  // read sequencer: linear address within bank
  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      bank <= '0;
      addr <= '0;
    end else if (state == IDLE) begin
      bank <= '0;
      addr <= '0;
    end else if (issue) begin
      if (addr == A_LAST) begin
        addr <= '0;
        bank <= bank + KW'(1);
      end else begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  // latency pipe tags each read with its bank
  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      pv <= '0;
      for (int k = 0; k < BRAM_LAT; k++) pb[k] <= '0;
    end else begin
      if (stage_abort) begin
        pv <= '0;
      end else begin
        pv[0] <= issue;
        for (int k = 1; k < BRAM_LAT; k++) pv[k] <= pv[k-1];
      end
      pb[0] <= bank;
      for (int k = 1; k < BRAM_LAT; k++) pb[k] <= pb[k-1];
    end
  end

  // return FIFO and beat slicer
  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      pend <= '0;
      beat <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (stage_abort) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      pend <= '0;
      beat <= '0;
    end else begin
      if (cap) begin
        mem[wp] <= bram_doutb[
          int'(pb[BRAM_LAT-1])*BRAM_DW +: BRAM_DW];
        wp <= (wp == P_LAST) ? '0 : wp + PW'(1);
      end
      if (xfer)
        beat <= (beat == B_LAST) ? '0 : beat + BW'(1);
      if (pop)
        rp <= (rp == P_LAST) ? '0 : rp + PW'(1);
      cnt  <= cnt + CW'(cap) - CW'(pop);
      pend <= pend + CW'(issue) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_dout_bank_serializer.sv
// Bench for dout_bank_serializer: 2 banks x 2 rows x 3 words,
// two instances with BRAM latency 1 and 3.
module tb_dout_bank_serializer;
  localparam int NB = 2, RPB = 2, WPR = 3;
  localparam int AW = 14, NBEAT = NB * RPB * WPR * 2;

  logic clk = 1'b0;
  logic rst_n, start, abort, rdy, sel;
  logic [NB-1:0] enb1, enb3;
  logic [NB*AW-1:0] addr1, addr3;
  logic [NB*64-1:0] dout1, dout3;
  logic busy1, busy3, fd1, fd3;
  logic [63:0] q1 [NB];
  logic [63:0] q3a [NB];
  logic [63:0] q3b [NB];
  logic [63:0] q3c [NB];
  logic v, bz, fd;
  logic [31:0] d;
  logic [NB-1:0] enb;
  logic [31:0] exp_q [$];
  int vec = 0, bad = 0;

  always #5 clk = ~clk;

  dout_bank_serializer_if #(.AXI_DW(32)) if1 ();
  dout_bank_serializer_if #(.AXI_DW(32)) if3 ();

  assign if1.write_ready = sel ? 1'b1 : rdy;
  assign if3.write_ready = sel ? rdy : 1'b1;

  dout_bank_serializer #(
    .NUM_BANKS(NB), .ROWS_PER_BANK(RPB), .WORDS_PER_ROW(WPR),
    .BRAM_DW(64), .AXI_DW(32), .ADDR_W(AW), .BRAM_LAT(1)
  ) u1 (
    .axi_ACLK(clk), .axi_ARESETN(rst_n),
    .stage_start(start), .stage_abort(abort), .wr(if1),
    .bram_enb(enb1), .bram_addrb(addr1), .bram_doutb(dout1),
    .busy(busy1), .frame_done(fd1)
  );

  dout_bank_serializer #(
    .NUM_BANKS(NB), .ROWS_PER_BANK(RPB), .WORDS_PER_ROW(WPR),
    .BRAM_DW(64), .AXI_DW(32), .ADDR_W(AW), .BRAM_LAT(3)
  ) u3 (
    .axi_ACLK(clk), .axi_ARESETN(rst_n),
    .stage_start(start), .stage_abort(abort), .wr(if3),
    .bram_enb(enb3), .bram_addrb(addr3), .bram_doutb(dout3),
    .busy(busy3), .frame_done(fd3)
  );

  function automatic logic [63:0] word(int b, int a);
    return {16'hB000 + 16'(b), 16'(a), 16'hA000 + 16'(b), 16'(a)};
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (enb1[b]) q1[b] <= word(b, int'(addr1[b*AW +: AW]));
      if (enb3[b]) q3a[b] <= word(b, int'(addr3[b*AW +: AW]));
      q3b[b] <= q3a[b];
      q3c[b] <= q3b[b];
    end
  end

  assign dout1 = {q1[1], q1[0]};
  assign dout3 = {q3c[1], q3c[0]};

  always_comb begin
    v   = sel ? if3.write_valid : if1.write_valid;
    d   = sel ? if3.write_data : if1.write_data;
    enb = sel ? enb3 : enb1;
    bz  = sel ? busy3 : busy1;
    fd  = sel ? fd3 : fd1;
  end

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    vec++; if (if1.write_valid !== 1'b0) begin bad++;
      $display("FAIL rst_valid got %b want 0", if1.write_valid); end
    vec++; if (if1.write_data !== 32'h0) begin bad++;
      $display("FAIL rst_data got %h want 0", if1.write_data); end
    vec++; if (enb1 !== '0 || enb3 !== '0) begin bad++;
      $display("FAIL rst_enb got %b/%b want 0", enb1, enb3); end
    vec++; if (addr1 !== '0) begin bad++;
      $display("FAIL rst_addr got %h want 0", addr1); end
    vec++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin bad++;
      $display("FAIL rst_busy got %b/%b want 0", busy1, busy3); end
    vec++; if (fd1 !== 1'b0) begin bad++;
      $display("FAIL rst_done got %b want 0", fd1); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_frame(input logic s, input int pct,
                            input int stall, input int ab_at,
                            input int rp_at);
    int idx = 0, fdn = 0, reads = 0, cyc;
    logic pst = 1'b0, acc = 1'b0;
    logic [31:0] pd = '0;
    sel = s;
    rdy = (stall == 0) && ($urandom_range(99) < pct);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      vec++; if ($countones(enb) > 1) begin bad++;
        $display("FAIL onehot enb=%b want <=1 bit", enb); end
      if (stall > 0 && !acc) reads += $countones(enb);
      if (pst) begin
        vec++; if (v !== 1'b1 || d !== pd) begin bad++;
          $display("FAIL stall_hold v=%b d=%h want 1 %h", v, d, pd);
        end
      end
      if (fd) begin
        fdn++;
        vec++; if (idx != NBEAT) begin bad++;
          $display("FAIL done_early at beat %0d want %0d", idx, NBEAT);
        end
      end
      if (v && rdy) begin
        vec++;
        if (idx >= NBEAT) begin bad++;
          $display("FAIL extra_beat %h beyond %0d", d, NBEAT);
        end else if (d !== exp_q[idx]) begin bad++;
          $display("FAIL beat%0d got %h want %h", idx, d, exp_q[idx]);
        end
        idx++;
        acc = 1'b1;
      end
      pst = v && !rdy;
      pd = d;
      if (ab_at >= 0 && idx == ab_at) break;
      if (fdn > 0 && !bz) break;
      @(posedge clk); #1;
      rdy = (cyc < stall) ? 1'b0 : ($urandom_range(99) < pct);
      start = (rp_at > 0) && (idx == rp_at);
    end
    start = 1'b0;
    if (ab_at >= 0) begin
      @(posedge clk); #1 abort = 1'b1; rdy = 1'b0;
      @(posedge clk); #1 abort = 1'b0; rdy = 1'b1;
      @(negedge clk);
      vec++; if (v !== 1'b0) begin bad++;
        $display("FAIL abort_valid got %b want 0", v); end
      vec++; if (bz !== 1'b0) begin bad++;
        $display("FAIL abort_busy got %b want 0", bz); end
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (fd || v) fdn++;
      end
      vec++; if (fdn != 0) begin bad++;
        $display("FAIL abort_quiet got %0d events want 0", fdn); end
    end else begin
      vec++; if (idx != NBEAT) begin bad++;
        $display("FAIL beat_count got %0d want %0d", idx, NBEAT); end
      vec++; if (fdn != 1) begin bad++;
        $display("FAIL done_count got %0d want 1", fdn); end
      if (stall > 0) begin
        vec++; if (reads > 5 || reads < 1) begin bad++;
          $display("FAIL stall_reads got %0d want 1..5", reads); end
      end
    end
    rdy = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    sel = 1'b0; rdy = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    vec++; if (busy1 !== 1'b1) begin bad++;
      $display("FAIL mid_busy got %b want 1", busy1); end
    #1 rst_n = 1'b0;
    #1;
    vec++; if ({if1.write_valid, if1.write_data, enb1, addr1,
                busy1, fd1} !== '0) begin bad++;
      $display("FAIL mid_reset v=%b d=%h e=%b a=%h b=%b f=%b want 0",
               if1.write_valid, if1.write_data, enb1, addr1,
               busy1, fd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_start_held;
    int fdn = 0;
    sel = 1'b0; rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vec++; if (busy1 !== 1'b1) begin bad++;
      $display("FAIL held_start busy got %b want 1", busy1); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fd1) fdn++;
    end
    vec++; if (busy1 !== 1'b0 || fdn != 1) begin bad++;
      $display("FAIL held_start end busy=%b done=%0d want 0 1",
               busy1, fdn);
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [63:0] w;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    rdy = 1'b1; sel = 1'b0;
    for (int r = 0; r < NB * RPB; r++)
      for (int k = 0; k < WPR; k++) begin
        w = word(r / RPB, (r % RPB) * WPR + k);
        exp_q.push_back(w[31:0]);
        exp_q.push_back(w[63:32]);
      end
    test_reset();
    test_frame(1'b0, 100, 0, -1, 0);
    test_frame(1'b0, 30, 0, -1, 0);
    test_frame(1'b0, 30, 0, -1, 0);
    test_frame(1'b1, 100, 20, -1, 0);
    test_frame(1'b1, 50, 0, -1, 0);
    test_frame(1'b0, 100, 0, 10, 0);
    test_frame(1'b0, 100, 0, -1, 0);
    test_frame(1'b0, 70, 0, -1, 5);
    test_reset_mid();
    test_frame(1'b0, 100, 0, -1, 0);
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
